la_link_ctrl: RTL and testbench

- Link-bring-up and supervision controller for the LVDS logic-analyzer receive path.
- Drives the receiver's reset and sequences it through clock, phase and bit-slip lock.
- While the link is up, monitors lock and packet activity; retrains with backoff on failure.
- Latches a fault after repeated failed retrains.
- Runs in the free-running reference-clock domain; all receiver-side inputs are asynchronous to it.

---
 rtl/la_link_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_la_link_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_link_ctrl.sv
// Link bring-up and supervision controller for the LVDS logic-analyzer receive path.
// Sequences receiver reset and lock acquisition, supervises the running link, retrains with backoff.
module la_link_ctrl #(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned IDLE_TIMEOUT   = 4000000,
    parameter int unsigned BACKOFF_CYCLES = 65536,
    parameter int unsigned MAX_RETRY      = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       clear_fault,
    input  logic [2:0] lock_level,
    input  logic       pkt_toggle,
    output logic       rx_reset,
    output logic       link_up,
    output logic [2:0] state_out,
    output logic [3:0] retry_count,
    output logic [1:0] fail_cause,
    output logic       fault,
    output logic [7:0] relock_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RESET_RX = 3'd1,
        S_WAIT_CLK = 3'd2,
        S_WAIT_PS  = 3'd3,
        S_WAIT_BS  = 3'd4,
        S_RUN      = 3'd5,
        S_BACKOFF  = 3'd6,
        S_FAULT    = 3'd7
    } state_t;

    localparam logic [23:0] RESET_LAST   = 24'(RESET_CYCLES - 1);
    localparam logic [23:0] LOCK_LAST    = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] IDLE_LAST    = 24'(IDLE_TIMEOUT - 1);
    localparam logic [23:0] BACKOFF_LAST = 24'(BACKOFF_CYCLES - 1);
    localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
    localparam logic [1:0] CAUSE_LOST    = 2'd2;
    localparam logic [1:0] CAUSE_IDLE    = 2'd3;

    state_t      r_state;
    state_t      w_next;
    logic [23:0] r_timer;
    logic [23:0] w_timer_nxt;
    logic [1:0]  w_cause;
    logic        w_rx_reset;
    logic        w_enter_backoff;
    logic        w_enter_run;
    logic        w_fault_clear;

    logic [2:0]  r_lock_m;
    logic [2:0]  r_lock_s;
    logic        r_tog_m;
    logic        r_tog_s;
    logic        r_tog_d;
    logic        w_pkt_seen;

    logic        r_rx_reset;
    logic        r_link_up;
    logic [3:0]  r_retry;
    logic [1:0]  r_cause;
    logic        r_fault;
    logic [7:0]  r_relock;

    // Receiver-domain inputs: two-flop synchronizers, plus an edge detector on the packet toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_m <= '0;
            r_lock_s <= '0;
            r_tog_m  <= 1'b0;
            r_tog_s  <= 1'b0;
            r_tog_d  <= 1'b0;
        end else begin
            r_lock_m <= lock_level;
            r_lock_s <= r_lock_m;
            r_tog_m  <= pkt_toggle;
            r_tog_s  <= r_tog_m;
            r_tog_d  <= r_tog_s;
        end
    end

    assign w_pkt_seen = r_tog_s ^ r_tog_d;

    always_comb begin
        w_next  = r_state;
        w_cause = CAUSE_NONE;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_RESET_RX;
                S_RESET_RX: begin
                    if (r_timer == RESET_LAST) w_next = S_WAIT_CLK;
                end
                S_WAIT_CLK: begin
                    if (r_lock_s[0]) begin
                        w_next = S_WAIT_PS;
                    end else if (r_timer == LOCK_LAST) begin
                        w_next  = S_BACKOFF;
                        w_cause = CAUSE_TIMEOUT;
                    end
                end
                S_WAIT_PS: begin
                    if (r_lock_s[1:0] == 2'b11) begin
                        w_next = S_WAIT_BS;
                    end else if (!r_lock_s[0]) begin
                        w_next  = S_BACKOFF;
                        w_cause = CAUSE_LOST;
                    end else if (r_timer == LOCK_LAST) begin
                        w_next  = S_BACKOFF;
                        w_cause = CAUSE_TIMEOUT;
                    end
                end
                S_WAIT_BS: begin
                    if (r_lock_s == 3'b111) begin
                        w_next = S_RUN;
                    end else if (r_lock_s[1:0] != 2'b11) begin
                        w_next  = S_BACKOFF;
                        w_cause = CAUSE_LOST;
                    end else if (r_timer == LOCK_LAST) begin
                        w_next  = S_BACKOFF;
                        w_cause = CAUSE_TIMEOUT;
                    end
                end
                S_RUN: begin
                    if (r_lock_s != 3'b111) begin
                        w_next  = S_BACKOFF;
                        w_cause = CAUSE_LOST;
                    end else if (!w_pkt_seen && r_timer == IDLE_LAST) begin
                        w_next  = S_BACKOFF;
                        w_cause = CAUSE_IDLE;
                    end
                end
                S_BACKOFF: begin
                    // retry_count already holds the value incremented on entry.
                    if (r_retry >= RETRY_LIMIT) w_next = S_FAULT;
                    else if (r_timer == BACKOFF_LAST) w_next = S_RESET_RX;
                end
                S_FAULT: begin
                    if (clear_fault) w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_timer_nxt = r_timer + 24'd1;
        if (w_next != r_state) w_timer_nxt = '0;
        else if (r_state == S_RUN && w_pkt_seen) w_timer_nxt = '0;
    end

    assign w_rx_reset      = (w_next == S_IDLE) || (w_next == S_RESET_RX) ||
                             (w_next == S_BACKOFF) || (w_next == S_FAULT);
    assign w_enter_backoff = (w_next == S_BACKOFF) && (r_state != S_BACKOFF);
    assign w_enter_run     = (w_next == S_RUN) && (r_state != S_RUN);
    assign w_fault_clear   = (r_state == S_FAULT) && enable && clear_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_rx_reset <= 1'b1;
            r_link_up  <= 1'b0;
            r_retry    <= '0;
            r_cause    <= CAUSE_NONE;
            r_fault    <= 1'b0;
            r_relock   <= '0;
        end else begin
            r_state    <= w_next;
            r_timer    <= w_timer_nxt;
            r_rx_reset <= w_rx_reset;
            r_link_up  <= (w_next == S_RUN);
            if (w_enter_backoff) begin
                r_cause <= w_cause;
                if (r_retry != 4'hF) r_retry <= r_retry + 4'd1;
                if (r_state == S_RUN && r_relock != 8'hFF) r_relock <= r_relock + 8'd1;
            end
            if (w_enter_run) begin
                r_retry <= '0;
                r_cause <= CAUSE_NONE;
            end
            if (w_next == S_FAULT) begin
                r_fault <= 1'b1;
            end else if (w_fault_clear) begin
                r_fault <= 1'b0;
                r_retry <= '0;
            end
        end
    end

    assign state_out   = r_state;
    assign rx_reset    = r_rx_reset;
    assign link_up     = r_link_up;
    assign retry_count = r_retry;
    assign fail_cause  = r_cause;
    assign fault       = r_fault;
    assign relock_cnt  = r_relock;

endmodule

// File: tb/tb_la_link_ctrl.sv
// Directed bench for la_link_ctrl: expectations queued as stimulus is applied, popped as outputs are sampled.
module tb_la_link_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       clear_fault;
    logic [2:0] lock_level;
    logic       pkt_toggle;
    logic       rx_reset;
    logic       link_up;
    logic [2:0] state_out;
    logic [3:0] retry_count;
    logic [1:0] fail_cause;
    logic       fault;
    logic [7:0] relock_cnt;

    la_link_ctrl #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (32),
        .IDLE_TIMEOUT  (16),
        .BACKOFF_CYCLES(8),
        .MAX_RETRY     (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .clear_fault(clear_fault),
        .lock_level (lock_level),
        .pkt_toggle (pkt_toggle),
        .rx_reset   (rx_reset),
        .link_up    (link_up),
        .state_out  (state_out),
        .retry_count(retry_count),
        .fail_cause (fail_cause),
        .fault      (fault),
        .relock_cnt (relock_cnt)
    );

    always #5 clk = ~clk;

    string       q_tag[$];
    logic [31:0] q_exp[$];
    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic        tog_en;
    int unsigned tog_period;
    int unsigned tog_cnt;

    task automatic expect_val(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic got(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h with no expectation queued", obs);
        end else begin
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            n_cmp++;
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    // Sample 1 time unit after the rising edge; packet toggles are generated here too.
    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                tog_cnt++;
                if (tog_cnt >= tog_period) begin
                    pkt_toggle = ~pkt_toggle;
                    tog_cnt    = 0;
                end
            end
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int unsigned budget);
        int unsigned k;
        k = 0;
        expect_val(tag, 32'd1);
        while (state_out !== s && k < budget) begin
            tick(1);
            k++;
        end
        got({31'd0, state_out === s});
    endtask

    task automatic expect_reset_values(input string tag);
        expect_val({tag, "_state"}, 32'd0);
        expect_val({tag, "_rx_reset"}, 32'd1);
        expect_val({tag, "_link_up"}, 32'd0);
        expect_val({tag, "_retry"}, 32'd0);
        expect_val({tag, "_cause"}, 32'd0);
        expect_val({tag, "_fault"}, 32'd0);
        expect_val({tag, "_relock"}, 32'd0);
    endtask

    task automatic got_all_outputs();
        got({29'd0, state_out});
        got({31'd0, rx_reset});
        got({31'd0, link_up});
        got({28'd0, retry_count});
        got({30'd0, fail_cause});
        got({31'd0, fault});
        got({24'd0, relock_cnt});
    endtask

    initial begin
        int unsigned cnt;
        int unsigned bad;

        rst_n       = 1'b0;
        enable      = 1'b0;
        clear_fault = 1'b0;
        lock_level  = 3'b000;
        pkt_toggle  = 1'b0;
        tog_en      = 1'b0;
        tog_period  = 4;
        tog_cnt     = 0;

        expect_reset_values("por");
        tick(3);
        got_all_outputs();
        rst_n = 1'b1;
        tick(1);

        // Bring-up with staggered lock bits and a packet toggle every 4 cycles.
        tog_en = 1'b1;
        enable = 1'b1;
        expect_val("enter_reset_rx", 32'd1);
        expect_val("rx_reset_cycles", 32'd4);
        tick(1);
        got({29'd0, state_out});
        cnt = 0;
        while (state_out == 3'd1 && rx_reset == 1'b1 && cnt < 50) begin
            cnt++;
            tick(1);
        end
        got(cnt);
        expect_val("wait_clk_state", 32'd2);
        expect_val("wait_clk_rx_reset", 32'd0);
        got({29'd0, state_out});
        got({31'd0, rx_reset});

        lock_level = 3'b001;
        expect_val("wait_ps_state", 32'd3);
        tick(5);
        got({29'd0, state_out});
        lock_level = 3'b011;
        expect_val("wait_bs_state", 32'd4);
        tick(5);
        got({29'd0, state_out});
        lock_level = 3'b111;
        expect_val("run_state", 32'd5);
        expect_val("run_link_up", 32'd1);
        expect_val("run_retry", 32'd0);
        expect_val("run_rx_reset", 32'd0);
        tick(5);
        got({29'd0, state_out});
        got({31'd0, link_up});
        got({28'd0, retry_count});
        got({31'd0, rx_reset});

        expect_val("hold_200_drops", 32'd0);
        bad = 0;
        for (int unsigned i = 0; i < 200; i++) begin
            tick(1);
            if (link_up !== 1'b1 || state_out !== 3'd5) bad++;
        end
        got(bad);

        // One-cycle glitch on bit-slip lock.
        lock_level = 3'b011;
        expect_val("glitch_state", 32'd6);
        expect_val("glitch_cause", 32'd2);
        expect_val("glitch_relock", 32'd1);
        expect_val("glitch_rx_reset", 32'd1);
        expect_val("glitch_link_up", 32'd0);
        expect_val("glitch_retry", 32'd1);
        tick(1);
        lock_level = 3'b111;
        tick(2);
        got({29'd0, state_out});
        got({30'd0, fail_cause});
        got({24'd0, relock_cnt});
        got({31'd0, rx_reset});
        got({31'd0, link_up});
        got({28'd0, retry_count});
        expect_val("backoff_hold", 32'd6);
        tick(7);
        got({29'd0, state_out});
        expect_val("backoff_exit", 32'd1);
        tick(1);
        got({29'd0, state_out});
        wait_state("relock_run", 3'd5, 40);
        expect_val("relock_retry", 32'd0);
        expect_val("relock_cause", 32'd0);
        expect_val("relock_relock", 32'd1);
        got({28'd0, retry_count});
        got({30'd0, fail_cause});
        got({24'd0, relock_cnt});

        // Packets 15 cycles apart must keep the link up.
        tog_period = 15;
        tog_cnt    = 0;
        pkt_toggle = ~pkt_toggle;
        expect_val("spacing15_drops", 32'd0);
        bad = 0;
        for (int unsigned i = 0; i < 100; i++) begin
            tick(1);
            if (state_out !== 3'd5) bad++;
        end
        got(bad);

        // Last packet, then silence: trip 16 cycles after it is seen.
        tog_en = 1'b0;
        tick(1);
        pkt_toggle = ~pkt_toggle;
        expect_val("idle_not_yet", 32'd5);
        tick(18);
        got({29'd0, state_out});
        expect_val("idle_state", 32'd6);
        expect_val("idle_cause", 32'd3);
        expect_val("idle_relock", 32'd2);
        expect_val("idle_retry", 32'd1);
        tick(1);
        got({29'd0, state_out});
        got({30'd0, fail_cause});
        got({24'd0, relock_cnt});
        got({28'd0, retry_count});
        tog_period = 4;
        tog_cnt    = 0;
        tog_en     = 1'b1;
        wait_state("idle_relock_run", 3'd5, 60);

        // Enable drop in RUN.
        enable     = 1'b0;
        lock_level = 3'b000;
        expect_val("dis_run_state", 32'd0);
        expect_val("dis_run_rx_reset", 32'd1);
        expect_val("dis_run_link_up", 32'd0);
        tick(1);
        got({29'd0, state_out});
        got({31'd0, rx_reset});
        got({31'd0, link_up});
        tick(4);

        // Lock never arrives: three WAIT_CLK timeouts, then FAULT.
        enable = 1'b1;
        for (int unsigned i = 1; i <= 3; i++) begin
            wait_state("reach_wait_clk", 3'd2, 40);
            expect_val("wait_clk_cycles", 32'd32);
            cnt = 0;
            while (state_out == 3'd2 && cnt < 100) begin
                cnt++;
                tick(1);
            end
            got(cnt);
            expect_val("timeout_state", 32'd6);
            expect_val("timeout_retry", i);
            expect_val("timeout_cause", 32'd1);
            got({29'd0, state_out});
            got({28'd0, retry_count});
            got({30'd0, fail_cause});
            if (i == 2) begin
                clear_fault = 1'b1;
                expect_val("clear_ignored_state", 32'd6);
                expect_val("clear_ignored_retry", 32'd2);
                tick(1);
                clear_fault = 1'b0;
                got({29'd0, state_out});
                got({28'd0, retry_count});
            end
        end
        expect_val("fault_state", 32'd7);
        expect_val("fault_flag", 32'd1);
        expect_val("fault_cause", 32'd1);
        expect_val("fault_rx_reset", 32'd1);
        tick(1);
        got({29'd0, state_out});
        got({31'd0, fault});
        got({30'd0, fail_cause});
        got({31'd0, rx_reset});

        clear_fault = 1'b1;
        expect_val("clear_state", 32'd0);
        expect_val("clear_fault_flag", 32'd0);
        expect_val("clear_retry", 32'd0);
        expect_val("clear_keeps_cause", 32'd1);
        tick(1);
        clear_fault = 1'b0;
        got({29'd0, state_out});
        got({31'd0, fault});
        got({28'd0, retry_count});
        got({30'd0, fail_cause});
        expect_val("reattempt_state", 32'd1);
        tick(1);
        got({29'd0, state_out});

        // Enable drop in WAIT_PS.
        lock_level = 3'b001;
        wait_state("reach_wait_ps", 3'd3, 40);
        expect_val("wait_ps_rx_reset", 32'd0);
        got({31'd0, rx_reset});
        enable = 1'b0;
        expect_val("dis_ps_state", 32'd0);
        expect_val("dis_ps_rx_reset", 32'd1);
        expect_val("dis_ps_link_up", 32'd0);
        tick(1);
        got({29'd0, state_out});
        got({31'd0, rx_reset});
        got({31'd0, link_up});

        // Asynchronous reset while in BACKOFF.
        lock_level = 3'b000;
        tick(3);
        enable = 1'b1;
        wait_state("reach_backoff", 3'd6, 100);
        expect_val("pre_reset_retry", 32'd1);
        got({28'd0, retry_count});
        tick(2);
        #3;
        rst_n = 1'b0;
        expect_reset_values("async");
        #1;
        got_all_outputs();
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
